// File: rtl/bp_piton_l15_return_adapter.sv
// -----------------------------------------------------------------------------
// bp_piton_l15_return_adapter
//
// Purpose:
//   Accepts returns from the OpenPiton L1.5 and sorts them by type.
//   - Fill returns (LOAD_RET, IFILL_RET, ATOMIC_RET) are buffered in a small
//     FIFO and presented to the cache with a valid/ready handshake.
//   - EVICT_REQ becomes a one-cycle invalidation pulse.
//   - ST_ACK becomes a one-cycle store-ack pulse.
//   - Unknown return types are acked, dropped, and set a sticky error flag.
//   Only fill returns can be back-pressured (FIFO full). Every other type is
//   acked in the cycle it is presented.
//
// Parameters:
//   fifo_els_p   : return-buffer depth (2 or 4)
//   fill_width_p : fill data width (128 or 256)
//
// Ports:
//   clk_i                        : clock
//   reset_i                      : asynchronous active-high reset
//   l15_transducer_val_i         : L1.5 return valid
//   l15_transducer_returntype_i  : return type code
//   l15_transducer_data_i        : {data_3, data_2, data_1, data_0}
//   l15_transducer_inval_addr_i  : invalidation address bits [15:4]
//   transducer_l15_ack_o         : return accepted (combinational)
//   fill_v_o / fill_ready_and_i  : fill valid / consumer ready
//   fill_icache_o                : 1 = ifill, 0 = dcache load or atomic
//   fill_data_o                  : fill data
//   inval_v_o / inval_addr_o     : invalidation pulse and held address
//   st_ack_o                     : store-ack pulse
//   err_o                        : sticky unknown-returntype flag
// -----------------------------------------------------------------------------
module bp_piton_l15_return_adapter #(
   parameter int fifo_els_p   = 2,
   parameter int fill_width_p = 256
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    l15_transducer_val_i,
   input  logic [3:0]              l15_transducer_returntype_i,
   input  logic [255:0]            l15_transducer_data_i,
   input  logic [11:0]             l15_transducer_inval_addr_i,
   output logic                    transducer_l15_ack_o,
   output logic                    fill_v_o,
   input  logic                    fill_ready_and_i,
   output logic                    fill_icache_o,
   output logic [fill_width_p-1:0] fill_data_o,
   output logic                    inval_v_o,
   output logic [11:0]             inval_addr_o,
   output logic                    st_ack_o,
   output logic                    err_o
);

   localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

   localparam logic [3:0] LOAD_RET   = 4'h0;
   localparam logic [3:0] IFILL_RET  = 4'h1;
   localparam logic [3:0] EVICT_REQ  = 4'h3;
   localparam logic [3:0] ST_ACK     = 4'h4;
   localparam logic [3:0] ATOMIC_RET = 4'hE;

   // ---------------------------------------------------------------- decode
   logic is_load, is_ifill, is_atomic, is_fill, is_evict, is_st, is_unknown;

   assign is_load    = (l15_transducer_returntype_i == LOAD_RET);
   assign is_ifill   = (l15_transducer_returntype_i == IFILL_RET);
   assign is_atomic  = (l15_transducer_returntype_i == ATOMIC_RET);
   assign is_evict   = (l15_transducer_returntype_i == EVICT_REQ);
   assign is_st      = (l15_transducer_returntype_i == ST_ACK);
   assign is_fill    = is_load | is_ifill | is_atomic;
   assign is_unknown = ~(is_fill | is_evict | is_st);

   // ---------------------------------------------------------------- FIFO state
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0] cnt_q,    cnt_d;

   // Each entry is {icache bit, data}. Storage is deliberately not reset:
   // only the pointers and occupancy define what is valid.
   logic [fill_width_p:0] mem_q [fifo_els_p];
   logic [fill_width_p:0] head;
   logic [fill_width_p-1:0] wr_data;

   logic full, enq, deq, ack;

   assign full     = (cnt_q == cnt_w_lp'(fifo_els_p));
   assign fill_v_o = (cnt_q != '0);
   assign deq      = fill_v_o & fill_ready_and_i;

   // A fill may enter a full FIFO when the head leaves in the same cycle.
   // Reset gates the ack so nothing is accepted while state is being cleared.
   assign ack = l15_transducer_val_i & ~reset_i & (~is_fill | ~full | deq);
   assign enq = ack & is_fill;

   assign transducer_l15_ack_o = ack;

   generate
      if (fill_width_p == 256) begin : g_w256
         assign wr_data = l15_transducer_data_i;
      end else begin : g_w128
         // Atomic results live in data_0; replicate so either 64-bit half
         // of the narrow fill carries the result.
         assign wr_data = is_atomic ? {2{l15_transducer_data_i[63:0]}}
                                    : l15_transducer_data_i[127:0];
         logic unused_upper_data;
         assign unused_upper_data = ^l15_transducer_data_i[255:128];
      end
   endgenerate

   function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (enq) wr_ptr_d = bump(wr_ptr_q);
      if (deq) rd_ptr_d = bump(rd_ptr_q);
      case ({enq, deq})
         2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
         2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= {is_ifill, wr_data};
   end

   assign head          = mem_q[rd_ptr_q];
   assign fill_icache_o = head[fill_width_p];
   assign fill_data_o   = head[fill_width_p-1:0];

   // ---------------------------------------------------------------- side-band
   logic        inval_v_q, inval_v_d;
   logic [11:0] inval_addr_q, inval_addr_d;
   logic        st_ack_q, st_ack_d;
   logic        err_q, err_d;

   always_comb begin
      inval_v_d    = ack & is_evict;
      inval_addr_d = (ack & is_evict) ? l15_transducer_inval_addr_i : inval_addr_q;
      st_ack_d     = ack & is_st;
      err_d        = err_q | (ack & is_unknown);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         cnt_q        <= '0;
         inval_v_q    <= 1'b0;
         inval_addr_q <= '0;
         st_ack_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         inval_v_q    <= inval_v_d;
         inval_addr_q <= inval_addr_d;
         st_ack_q     <= st_ack_d;
         err_q        <= err_d;
      end
   end

   assign inval_v_o    = inval_v_q;
   assign inval_addr_o = inval_addr_q;
   assign st_ack_o     = st_ack_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_bp_piton_l15_return_adapter.sv
// -----------------------------------------------------------------------------
// tb_bp_piton_l15_return_adapter
//
// Table-driven check of the L1.5 return adapter (fifo_els_p = 2, 256-bit
// fills). Each vector is driven on the falling edge; the combinational ack
// is sampled 1 ns later, and registered outputs 1 ns after the next rising
// edge. A hand-written sequence covers asynchronous reset with fills buffered.
// -----------------------------------------------------------------------------
module tb_bp_piton_l15_return_adapter;

   localparam logic [255:0] D_A = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
   localparam logic [255:0] D_B = 256'h1111111111111111222222222222222233333333333333334444444444444444;
   localparam logic [255:0] D_C = 256'hC0C0C0C0C0C0C0C0A5A5A5A5A5A5A5A5DEADBEEFDEADBEEF0F0F0F0F0F0F0F0F;
   localparam logic [255:0] D_D = 256'h00000000000000000000000000000000FFFFFFFFFFFFFFFF00000000DDDDDDDD;
   localparam logic [255:0] D_E = 256'h0000000000000000000000000000000000000000000000000000000012345678;

   localparam logic [3:0] T_LOAD = 4'h0, T_IFILL = 4'h1, T_EVICT = 4'h3,
                          T_ST = 4'h4, T_ATOM = 4'hE, T_BAD = 4'h7;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         val_i;
   logic [3:0]   rtype_i;
   logic [255:0] data_i;
   logic [11:0]  addr_i;
   logic         ack_o;
   logic         fill_v_o;
   logic         ready_i;
   logic         fill_icache_o;
   logic [255:0] fill_data_o;
   logic         inval_v_o;
   logic [11:0]  inval_addr_o;
   logic         st_ack_o;
   logic         err_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   bp_piton_l15_return_adapter #(.fifo_els_p(2), .fill_width_p(256)) dut (
      .clk_i                       (clk_i),
      .reset_i                     (reset_i),
      .l15_transducer_val_i        (val_i),
      .l15_transducer_returntype_i (rtype_i),
      .l15_transducer_data_i       (data_i),
      .l15_transducer_inval_addr_i (addr_i),
      .transducer_l15_ack_o        (ack_o),
      .fill_v_o                    (fill_v_o),
      .fill_ready_and_i            (ready_i),
      .fill_icache_o               (fill_icache_o),
      .fill_data_o                 (fill_data_o),
      .inval_v_o                   (inval_v_o),
      .inval_addr_o                (inval_addr_o),
      .st_ack_o                    (st_ack_o),
      .err_o                       (err_o)
   );

   typedef struct {
      logic         val;
      logic [3:0]   rtype;
      logic [255:0] data;
      logic [11:0]  addr;
      logic         ready;
      logic         exp_ack;
      logic         exp_fill_v;
      logic         exp_icache;
      logic [255:0] exp_data;
      logic         exp_inval_v;
      logic [11:0]  exp_inval_addr;
      logic         exp_st_ack;
      logic         exp_err;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic v, input logic [3:0] t, input logic [255:0] d,
                               input logic [11:0] a, input logic rdy, input logic e_ack,
                               input logic e_fv, input logic e_ic, input logic [255:0] e_d,
                               input logic e_iv, input logic [11:0] e_ia,
                               input logic e_st, input logic e_err);
      vec_t r;
      r.val = v; r.rtype = t; r.data = d; r.addr = a; r.ready = rdy;
      r.exp_ack = e_ack; r.exp_fill_v = e_fv; r.exp_icache = e_ic; r.exp_data = e_d;
      r.exp_inval_v = e_iv; r.exp_inval_addr = e_ia; r.exp_st_ack = e_st; r.exp_err = e_err;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   initial begin
      //              val type    data  addr    rdy ack  fv ic exp_data iv addr    st err
      vecs[0]  = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'h000, 0, 0); // idle after reset
      vecs[1]  = mk(1, T_IFILL, D_A, 12'h0,   1,  1,   1, 1, D_A, 0, 12'h000, 0, 0); // ifill, no bypass
      vecs[2]  = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'h000, 0, 0); // one-cycle dequeue
      vecs[3]  = mk(1, T_LOAD,  D_B, 12'h0,   0,  1,   1, 0, D_B, 0, 12'h000, 0, 0); // load 1
      vecs[4]  = mk(1, T_LOAD,  D_C, 12'h0,   0,  1,   1, 0, D_B, 0, 12'h000, 0, 0); // load 2 -> full
      vecs[5]  = mk(1, T_LOAD,  D_D, 12'h0,   0,  0,   1, 0, D_B, 0, 12'h000, 0, 0); // load 3 stalled
      vecs[6]  = mk(1, T_LOAD,  D_D, 12'h0,   1,  1,   1, 0, D_C, 0, 12'h000, 0, 0); // enq+deq at full
      vecs[7]  = mk(1, T_EVICT, '0,  12'hABC, 0,  1,   1, 0, D_C, 1, 12'hABC, 0, 0); // evict while full
      vecs[8]  = mk(0, T_LOAD,  '0,  12'h0,   0,  0,   1, 0, D_C, 0, 12'hABC, 0, 0); // pulse ends, addr held
      vecs[9]  = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   1, 0, D_D, 0, 12'hABC, 0, 0); // drain in order
      vecs[10] = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'hABC, 0, 0);
      vecs[11] = mk(1, T_ST,    '0,  12'h0,   1,  1,   0, 0, '0,  0, 12'hABC, 1, 0); // st ack (cycle N)
      vecs[12] = mk(1, T_ATOM,  D_E, 12'h0,   0,  1,   1, 0, D_E, 0, 12'hABC, 0, 0); // atomic (N+1)
      vecs[13] = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'hABC, 0, 0);
      vecs[14] = mk(1, T_BAD,   D_C, 12'h0,   1,  1,   0, 0, '0,  0, 12'hABC, 0, 1); // unknown type
      vecs[15] = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'hABC, 0, 1); // err sticky
      vecs[16] = mk(1, T_IFILL, D_A, 12'h0,   1,  1,   1, 1, D_A, 0, 12'hABC, 0, 1); // back-to-back
      vecs[17] = mk(1, T_LOAD,  D_B, 12'h0,   1,  1,   1, 0, D_B, 0, 12'hABC, 0, 1);
      vecs[18] = mk(0, T_LOAD,  '0,  12'h0,   1,  0,   0, 0, '0,  0, 12'hABC, 0, 1);

      reset_i = 1'b1; val_i = 1'b0; rtype_i = '0; data_i = '0; addr_i = '0; ready_i = 1'b0;
      #2;
      chk("reset_fill_v", 256'(fill_v_o), 256'(1'b0));
      chk("reset_ack",    256'(ack_o),    256'(1'b0));
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk_i);
         val_i = vecs[i].val; rtype_i = vecs[i].rtype; data_i = vecs[i].data;
         addr_i = vecs[i].addr; ready_i = vecs[i].ready;
         #1;
         chk($sformatf("v%0d_ack", i), 256'(ack_o), 256'(vecs[i].exp_ack));
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d_fill_v", i), 256'(fill_v_o), 256'(vecs[i].exp_fill_v));
         if (vecs[i].exp_fill_v) begin
            chk($sformatf("v%0d_icache", i), 256'(fill_icache_o), 256'(vecs[i].exp_icache));
            chk($sformatf("v%0d_data", i), fill_data_o, vecs[i].exp_data);
         end
         chk($sformatf("v%0d_inval_v", i),    256'(inval_v_o),    256'(vecs[i].exp_inval_v));
         chk($sformatf("v%0d_inval_addr", i), 256'(inval_addr_o), 256'(vecs[i].exp_inval_addr));
         chk($sformatf("v%0d_st_ack", i),     256'(st_ack_o),     256'(vecs[i].exp_st_ack));
         chk($sformatf("v%0d_err", i),        256'(err_o),        256'(vecs[i].exp_err));
         $display("vec %0d: val=%b type=%h ready=%b -> fill_v=%b icache=%b inval_v=%b st_ack=%b err=%b",
                  i, vecs[i].val, vecs[i].rtype, vecs[i].ready, fill_v_o, fill_icache_o,
                  inval_v_o, st_ack_o, err_o);
      end

      // Asynchronous reset with two fills buffered.
      @(negedge clk_i);
      val_i = 1'b1; rtype_i = T_LOAD; data_i = D_B; ready_i = 1'b0;
      #1 chk("rst_seq_ack1", 256'(ack_o), 256'(1'b1));
      @(negedge clk_i);
      data_i = D_C;
      #1 chk("rst_seq_ack2", 256'(ack_o), 256'(1'b1));
      @(posedge clk_i);
      #1 chk("rst_seq_fill_v_pre", 256'(fill_v_o), 256'(1'b1));
      #2 reset_i = 1'b1;
      #1;
      chk("rst_async_fill_v",     256'(fill_v_o),     256'(1'b0));
      chk("rst_async_err",        256'(err_o),        256'(1'b0));
      chk("rst_async_ack",        256'(ack_o),        256'(1'b0));
      chk("rst_async_inval_addr", 256'(inval_addr_o), 256'(12'h000));
      chk("rst_async_inval_v",    256'(inval_v_o),    256'(1'b0));
      chk("rst_async_st_ack",     256'(st_ack_o),     256'(1'b0));
      $display("reset asserted mid-cycle: fill_v=%b err=%b ack=%b", fill_v_o, err_o, ack_o);
      @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0; val_i = 1'b1; rtype_i = T_IFILL; data_i = D_A; ready_i = 1'b0;
      #1;
      chk("post_rst_fill_v", 256'(fill_v_o), 256'(1'b0));
      chk("post_rst_ack",    256'(ack_o),    256'(1'b1));
      @(posedge clk_i);
      #1;
      chk("post_rst_fill_v2", 256'(fill_v_o),      256'(1'b1));
      chk("post_rst_icache",  256'(fill_icache_o), 256'(1'b1));
      chk("post_rst_data",    fill_data_o,         D_A);
      chk("post_rst_err",     256'(err_o),         256'(1'b0));
      $display("first fill after reset: fill_v=%b icache=%b", fill_v_o, fill_icache_o);
      @(negedge clk_i);
      val_i = 1'b0; ready_i = 1'b1;
      @(posedge clk_i);
      #1 chk("post_rst_drain", 256'(fill_v_o), 256'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
